// File: rtl/mcu_el2_pmp_chk_seq_if.sv
// Request/response bundle between the IFU/LSU requesters and the PMP check engine.
// Latency: none (wires only).
// Backpressure: requesters hold *_req_valid until *_req_ready; the response cannot be stalled.
interface mcu_el2_pmp_chk_seq_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_mmode;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_write;
  logic        lsu_req_mmode;
  logic        rsp_valid;
  logic        rsp_id;
  logic        rsp_allow;
  logic        rsp_match;
  logic [5:0]  rsp_entry;

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_req_mmode,
    output lsu_req_valid, lsu_req_addr, lsu_req_write, lsu_req_mmode,
    input  ifu_req_ready, lsu_req_ready,
    input  rsp_valid, rsp_id, rsp_allow, rsp_match, rsp_entry
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_req_mmode,
    input  lsu_req_valid, lsu_req_addr, lsu_req_write, lsu_req_mmode,
    output ifu_req_ready, lsu_req_ready,
    output rsp_valid, rsp_id, rsp_allow, rsp_match, rsp_entry
  );
endinterface

// File: rtl/mcu_el2_pmp_chk_seq.sv
// Time-shared PMP checker: one comparator group scans entries for IFU and LSU requests in turn.
// Latency: handshake cycle, then 1..G SCAN cycles, then one registered RESP cycle.
// Backpressure: ready only in IDLE for the round-robin winner; the response strobe is never stalled.
module mcu_el2_pmp_chk_seq #(
  parameter int PMP_ENTRIES       = 16,
  parameter int ENTRIES_PER_CYCLE = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  mcu_el2_pmp_chk_seq_if.slave      io_bus,
  input  logic [8*PMP_ENTRIES-1:0]  i_pmp_cfg,
  input  logic [32*PMP_ENTRIES-1:0] i_pmp_addr,
  input  logic                      i_pmp_cfg_wr,
  output logic                      o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Access type doubles as the bit position of R/W/X in the cfg byte.
  localparam logic [1:0] ACC_R = 2'd0;
  localparam logic [1:0] ACC_W = 2'd1;
  localparam logic [1:0] ACC_X = 2'd2;

  localparam logic [5:0] IDX_STEP = 6'(ENTRIES_PER_CYCLE);
  localparam logic [5:0] IDX_LAST = 6'(PMP_ENTRIES - ENTRIES_PER_CYCLE);

  logic [1:0]  r_state;
  logic [5:0]  r_idx;
  logic [29:0] r_addr;
  logic [1:0]  r_acc;
  logic        r_mmode;
  logic        r_id;
  logic        r_rr_lsu;
  logic        r_rsp_id;
  logic        r_rsp_allow;
  logic        r_rsp_match;
  logic [5:0]  r_rsp_entry;

  logic        w_idle;
  logic        w_gnt_ifu;
  logic        w_gnt_lsu;
  logic        w_hit;
  logic [5:0]  w_hit_ent;
  logic        w_hit_allow;
  logic        w_unused;

  logic [7:0]  w_cfg  [ENTRIES_PER_CYCLE];
  logic [29:0] w_hi   [ENTRIES_PER_CYCLE];
  logic [29:0] w_lo   [ENTRIES_PER_CYCLE];
  logic [29:0] w_mask [ENTRIES_PER_CYCLE];
  logic [ENTRIES_PER_CYCLE-1:0] w_ent_match;

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    w_idle    = (r_state == S_IDLE) && !i_rst;
    w_gnt_ifu = w_idle && io_bus.ifu_req_valid && (!io_bus.lsu_req_valid || !r_rr_lsu);
    w_gnt_lsu = w_idle && io_bus.lsu_req_valid && (!io_bus.ifu_req_valid || r_rr_lsu);
  end

  // Match the current group of entries against the latched word address.
  always_comb begin
    for (int j = 0; j < ENTRIES_PER_CYCLE; j++) begin
      w_cfg[j] = i_pmp_cfg[(int'(r_idx) + j) * 8 +: 8];
      w_hi[j]  = i_pmp_addr[(int'(r_idx) + j) * 32 +: 30];
      if (int'(r_idx) + j == 0) begin
        w_lo[j] = '0;
      end else begin
        w_lo[j] = i_pmp_addr[(int'(r_idx) + j - 1) * 32 +: 30];
      end
      // P ^ (P+1) covers the trailing ones plus the first zero; all-ones P wraps to a zero mask.
      w_mask[j] = ~(w_hi[j] ^ (w_hi[j] + 30'd1));
      case (w_cfg[j][4:3])
        2'd1:    w_ent_match[j] = (w_lo[j] < w_hi[j]) && (r_addr >= w_lo[j]) && (r_addr < w_hi[j]);
        2'd2:    w_ent_match[j] = (r_addr == w_hi[j]);
        2'd3:    w_ent_match[j] = ((r_addr ^ w_hi[j]) & w_mask[j]) == '0;
        default: w_ent_match[j] = 1'b0;
      endcase
    end
  end

  // Lowest matching entry in the group wins; descending loop leaves it as the final assignment.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_ent   = '0;
    w_hit_allow = r_mmode;
    for (int j = ENTRIES_PER_CYCLE - 1; j >= 0; j--) begin
      if (w_ent_match[j]) begin
        w_hit       = 1'b1;
        w_hit_ent   = r_idx + 6'(j);
        w_hit_allow = (w_cfg[j][7] || !r_mmode) ? w_cfg[j][r_acc] : 1'b1;
      end
    end
  end

  // Request capture, group scan with rescan on CSR writes, and registered response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_acc       <= ACC_R;
      r_mmode     <= 1'b0;
      r_id        <= 1'b0;
      r_rr_lsu    <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_allow <= 1'b0;
      r_rsp_match <= 1'b0;
      r_rsp_entry <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_ifu || w_gnt_lsu) begin
            r_id     <= w_gnt_lsu;
            r_addr   <= w_gnt_lsu ? io_bus.lsu_req_addr[31:2] : io_bus.ifu_req_addr[31:2];
            r_acc    <= w_gnt_ifu ? ACC_X : (io_bus.lsu_req_write ? ACC_W : ACC_R);
            r_mmode  <= w_gnt_lsu ? io_bus.lsu_req_mmode : io_bus.ifu_req_mmode;
            r_rr_lsu <= w_gnt_ifu;
            r_idx    <= '0;
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (i_pmp_cfg_wr) begin
            r_idx <= '0;
          end else if (w_hit || (r_idx == IDX_LAST)) begin
            r_rsp_id    <= r_id;
            r_rsp_match <= w_hit;
            r_rsp_entry <= w_hit_ent;
            r_rsp_allow <= w_hit_allow;
            r_state     <= S_RESP;
          end else begin
            r_idx <= r_idx + IDX_STEP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.ifu_req_ready = w_gnt_ifu;
  assign io_bus.lsu_req_ready = w_gnt_lsu;
  assign io_bus.rsp_valid     = (r_state == S_RESP) && !i_rst;
  assign io_bus.rsp_id        = r_rsp_id & ~i_rst;
  assign io_bus.rsp_allow     = r_rsp_allow & ~i_rst;
  assign io_bus.rsp_match     = r_rsp_match & ~i_rst;
  assign io_bus.rsp_entry     = r_rsp_entry & {6{~i_rst}};
  assign o_busy               = (r_state != S_IDLE) && !i_rst;

  // Byte-offset and reserved bits never take part in matching.
  assign w_unused = ^{i_pmp_cfg, i_pmp_addr, io_bus.ifu_req_addr[1:0], io_bus.lsu_req_addr[1:0]};

endmodule

// File: tb/tb_mcu_el2_pmp_chk_seq.sv
// Self-checking bench for the sequential PMP checker.
// Table of requests against preset PMP layouts, then reset, arbitration and rescan sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mcu_el2_pmp_chk_seq;
  localparam int NE = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [8*NE-1:0] pmp_cfg;
  logic [32*NE-1:0] pmp_addr;
  logic            pmp_cfg_wr;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  mcu_el2_pmp_chk_seq_if bus();

  mcu_el2_pmp_chk_seq #(.PMP_ENTRIES(NE), .ENTRIES_PER_CYCLE(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .io_bus       (bus),
    .i_pmp_cfg    (pmp_cfg),
    .i_pmp_addr   (pmp_addr),
    .i_pmp_cfg_wr (pmp_cfg_wr),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    bit          lsu;
    logic [31:0] addr;
    bit          wr;
    bit          mm;
    bit          m;
    logic [5:0]  ent;
    bit          al;
    int          lat;
  } vec_t;

  vec_t vec [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_entry(input int idx, input logic [7:0] cfg, input logic [31:0] addr);
    pmp_cfg[idx*8 +: 8]   = cfg;
    pmp_addr[idx*32 +: 32] = addr;
  endtask

  task automatic load_cfg(input logic [1:0] sel);
    pmp_cfg  = '0;
    pmp_addr = '0;
    case (sel)
      2'd0: set_entry(5, 8'h19, 32'h0000_03FF);
      2'd1: begin
        set_entry(0, 8'h00, 32'h0000_0400);
        set_entry(1, 8'h89, 32'h0000_0800);
      end
      2'd2: begin
        set_entry(2, 8'h91, 32'h0000_0100);
        set_entry(3, 8'h9F, 32'h0000_01FF);
      end
      default: begin
        set_entry(0, 8'h09, 32'h0000_0010);
        set_entry(9, 8'h94, 32'h0000_2000);
        set_entry(12, 8'h98, 32'h3FFF_FFFF);
      end
    endcase
  endtask

  // Called on a falling edge in IDLE; returns on the falling edge of cycle 1.
  task automatic issue(input bit lsu, input logic [31:0] addr, input bit wr, input bit mm, input string tag);
    bit got;
    got = 1'b0;
    if (lsu) begin
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = addr;
      bus.lsu_req_write = wr;
      bus.lsu_req_mmode = mm;
    end else begin
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = addr;
      bus.ifu_req_mmode = mm;
    end
    for (int i = 0; i < 40; i++) begin
      #1;
      got = lsu ? bus.lsu_req_ready : bus.ifu_req_ready;
      @(posedge clk);
      if (got) break;
      @(negedge clk);
    end
    check({tag, " handshake"}, 32'(got), 32'd1);
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.ifu_req_valid = 1'b0;
  endtask

  // Starts on the falling edge of cycle 1; lat is the cycle holding rsp_valid, 0 when it never rises.
  task automatic wait_rsp(input string tag, output int lat);
    lat = 0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    for (int n = 1; n <= 40; n++) begin
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int seen;
    string tag;

    vec[0]  = '{2'd0, 1'b1, 32'h0000_1FFC, 1'b0, 1'b0, 1'b1, 6'd5,  1'b1, 3};
    vec[1]  = '{2'd0, 1'b0, 32'h0000_1FFC, 1'b0, 1'b0, 1'b1, 6'd5,  1'b0, 3};
    vec[2]  = '{2'd0, 1'b0, 32'h0000_1FFC, 1'b0, 1'b1, 1'b1, 6'd5,  1'b1, 3};
    vec[3]  = '{2'd0, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 5};
    vec[4]  = '{2'd0, 1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 5};
    vec[5]  = '{2'd1, 1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b1, 6'd1,  1'b0, 2};
    vec[6]  = '{2'd1, 1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 5};
    vec[7]  = '{2'd1, 1'b1, 32'h0000_1FFC, 1'b0, 1'b1, 1'b1, 6'd1,  1'b1, 2};
    vec[8]  = '{2'd1, 1'b1, 32'h0000_0FFC, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 5};
    vec[9]  = '{2'd2, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 1'b1, 6'd2,  1'b0, 2};
    vec[10] = '{2'd2, 1'b1, 32'h0000_0404, 1'b1, 1'b1, 1'b1, 6'd3,  1'b1, 2};
    vec[11] = '{2'd3, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 6'd0,  1'b0, 2};
    vec[12] = '{2'd3, 1'b1, 32'h0000_003C, 1'b0, 1'b0, 1'b1, 6'd0,  1'b1, 2};
    vec[13] = '{2'd3, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 6'd12, 1'b0, 5};
    vec[14] = '{2'd3, 1'b0, 32'h0000_8000, 1'b0, 1'b1, 1'b1, 6'd9,  1'b1, 4};
    vec[15] = '{2'd3, 1'b1, 32'h0000_8000, 1'b0, 1'b1, 1'b1, 6'd9,  1'b0, 4};

    rst = 1'b1;
    pmp_cfg_wr = 1'b0;
    pmp_cfg = '0;
    pmp_addr = '0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = '0;
    bus.ifu_req_mmode = 1'b0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = '0;
    bus.lsu_req_write = 1'b0;
    bus.lsu_req_mmode = 1'b0;

    // Power-on reset: no grants and quiet outputs while rst is high.
    @(negedge clk);
    check("rst ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    check("rst lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    @(negedge clk);
    check("post-rst busy", 32'(busy), 32'd0);
    check("post-rst rsp_entry", 32'(bus.rsp_entry), 32'd0);

    // Table of single requests.
    for (int i = 0; i < 16; i++) begin
      tag = $sformatf("v%0d", i);
      load_cfg(vec[i].sel);
      issue(vec[i].lsu, vec[i].addr, vec[i].wr, vec[i].mm, tag);
      wait_rsp(tag, lat);
      check({tag, " latency"}, 32'(lat), 32'(vec[i].lat));
      check({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(vec[i].lsu));
      check({tag, " rsp_match"}, 32'(bus.rsp_match), 32'(vec[i].m));
      check({tag, " rsp_entry"}, 32'(bus.rsp_entry), 32'(vec[i].ent));
      check({tag, " rsp_allow"}, 32'(bus.rsp_allow), 32'(vec[i].al));
      @(negedge clk);
      check({tag, " rsp_valid one cycle"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
    end

    // Reset during SCAN: no response, outputs cleared, IDLE afterwards.
    load_cfg(2'd0);
    issue(1'b1, 32'h0000_2000, 1'b0, 1'b1, "rstscan");
    @(negedge clk);
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1;
    #1;
    check("rstscan ready in rst", 32'(bus.ifu_req_ready), 32'd0);
    seen = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
      check($sformatf("rstscan ready c%0d", c), 32'(bus.ifu_req_ready), 32'd0);
    end
    check("rstscan rsp_match", 32'(bus.rsp_match), 32'd0);
    check("rstscan rsp_allow", 32'(bus.rsp_allow), 32'd0);
    rst = 1'b0;
    bus.ifu_req_valid = 1'b0;
    #1;
    check("rstscan busy after", 32'(busy), 32'd0);
    check("rstscan rsp_entry after", 32'(bus.rsp_entry), 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("rstscan no rsp", 32'(seen), 32'd0);

    // Arbitration: simultaneous requests serve IFU first, then LSU.
    load_cfg(2'd0);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_1FFC;
    bus.ifu_req_mmode = 1'b0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h0000_1FFC;
    bus.lsu_req_write = 1'b0;
    bus.lsu_req_mmode = 1'b0;
    #1;
    check("arb0 ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
    check("arb0 lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    wait_rsp("arb0", lat);
    check("arb0 latency", 32'(lat), 32'd3);
    check("arb0 rsp_id", 32'(bus.rsp_id), 32'd0);
    check("arb0 rsp_allow", 32'(bus.rsp_allow), 32'd0);
    bus.ifu_req_valid = 1'b1;
    @(negedge clk);
    #1;
    check("arb1 ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    check("arb1 lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    wait_rsp("arb1", lat);
    check("arb1 latency", 32'(lat), 32'd3);
    check("arb1 rsp_id", 32'(bus.rsp_id), 32'd1);
    check("arb1 rsp_allow", 32'(bus.rsp_allow), 32'd1);
    @(negedge clk);

    // Rescan: CSR write in scan cycle 3 restarts from entry 0 with the new layout.
    load_cfg(2'd1);
    issue(1'b1, 32'h0000_2000, 1'b1, 1'b1, "rescan");
    check("rescan busy", 32'(busy), 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
      if (n == 3) begin
        pmp_cfg_wr = 1'b1;
        set_entry(13, 8'h90, 32'h0000_0800);
      end else begin
        pmp_cfg_wr = 1'b0;
      end
      @(negedge clk);
    end
    pmp_cfg_wr = 1'b0;
    check("rescan latency", 32'(lat), 32'd8);
    check("rescan rsp_match", 32'(bus.rsp_match), 32'd1);
    check("rescan rsp_entry", 32'(bus.rsp_entry), 32'd13);
    check("rescan rsp_allow", 32'(bus.rsp_allow), 32'd0);
    check("rescan rsp_id", 32'(bus.rsp_id), 32'd1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
